morse_msg_sequencer: RTL and testbench

//  Sequences the Morse letter shift-register datapath to play a multi-letter message.
//  A host writes up to MAX_LEN 3-bit letter codes into an internal buffer, then pulses start.

---
 rtl/morse_msg_sequencer.sv | 147 ++++++++++++++
 tb/tb_morse_msg_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_msg_sequencer.sv
// Plays a buffered message of Morse letter codes by driving the shift-register datapath controls.
// Latency: outputs registered; first load one cycle after accepted start, first shift TICK_DIV cycles later.
// Backpressure: none; buffer writes and start are dropped while busy, abort wins over everything while busy.
module morse_msg_sequencer #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int PAT_W     = 14,
    parameter int GAP_UNITS = 3,
    parameter int MAX_LEN   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_code,
    input  logic [3:0] msg_len,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] sym_code,
    output logic       load_n,
    output logic       shift,
    output logic       sr_clear,
    output logic       busy,
    output logic       done,
    output logic [2:0] cur_idx
);

    localparam int GAP_CYC = GAP_UNITS * TICK_DIV;
    localparam int CNT_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BIT_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bits, bits_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [3:0]         len, len_nxt;
    logic [2:0]         msg_buf [MAX_LEN];
    logic               wr_ok;
    logic               in_play;
    logic               last_letter;
    logic [2:0]         sym_code_nxt;
    logic               load_n_nxt, shift_nxt, sr_clear_nxt, busy_nxt, done_nxt;

    assign wr_ok       = wr_en && !busy && (int'(wr_addr) < MAX_LEN);
    assign in_play     = (state == LOAD) || (state == SHIFT) || (state == GAP);
    assign last_letter = ({1'b0, idx} == (len - 4'd1));

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bits_nxt     = bits;
        idx_nxt      = idx;
        len_nxt      = len;
        sr_clear_nxt = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt   = (msg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : msg_len;
                    idx_nxt   = '0;
                    state_nxt = (msg_len == 4'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = CNT_W'(TICK_DIV - 1);
                bits_nxt  = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == '0) begin
                    cnt_nxt  = CNT_W'(TICK_DIV - 1);
                    bits_nxt = bits + 1'b1;
                    if (bits == BIT_W'(PAT_W - 1)) begin
                        if (last_letter) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = GAP;
                            cnt_nxt   = CNT_W'(GAP_CYC - 1);
                        end
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort also reports completion so the host sees one done per start.
        if (in_play && abort) begin
            state_nxt    = IDLE;
            sr_clear_nxt = 1'b1;
            done_nxt     = 1'b1;
        end

        if (state_nxt == DONE) done_nxt = 1'b1;
        load_n_nxt = (state_nxt != LOAD);
        shift_nxt  = (state_nxt == SHIFT) && (cnt_nxt == '0);
        busy_nxt   = (state_nxt == LOAD) || (state_nxt == SHIFT) || (state_nxt == GAP);

        sym_code_nxt = msg_buf[idx_nxt];
        if (wr_ok && (wr_addr == idx_nxt)) sym_code_nxt = wr_code;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            idx      <= '0;
            len      <= '0;
            sym_code <= '0;
            load_n   <= 1'b1;
            shift    <= 1'b0;
            sr_clear <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) msg_buf[i] <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bits     <= bits_nxt;
            idx      <= idx_nxt;
            len      <= len_nxt;
            sym_code <= sym_code_nxt;
            load_n   <= load_n_nxt;
            shift    <= shift_nxt;
            sr_clear <= sr_clear_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (wr_ok) msg_buf[wr_addr] <= wr_code;
        end
    end

    assign cur_idx = idx;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Scoreboard bench: expected load/shift/done events are queued with their cycle stamps when a message starts.
module tb_morse_msg_sequencer;

    localparam int TICK = 4;
    localparam int PW   = 14;
    localparam int GU   = 3;
    localparam int ML   = 8;
    localparam int LET  = 1 + PW * TICK;
    localparam int GAPC = GU * TICK;
    localparam int NOLIM = 1 << 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [2:0] wr_code = '0;
    logic [3:0] msg_len = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] sym_code;
    logic       load_n, shift, sr_clear, busy, done;
    logic [2:0] cur_idx;

    morse_msg_sequencer #(.TICK_DIV(TICK), .PAT_W(PW), .GAP_UNITS(GU), .MAX_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .msg_len(msg_len), .start(start), .abort(abort), .sym_code(sym_code), .load_n(load_n),
        .shift(shift), .sr_clear(sr_clear), .busy(busy), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 load, 1 shift, 2 done
        int cyc;
        int code;
        int idx;
        int bsy;
        int srclr;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  bcnt = 0;
    int  model_buf [ML];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int code, input int idx,
                           input int bsy, input int srclr);
        ev_t e;
        e.kind = kind; e.cyc = c; e.code = code; e.idx = idx; e.bsy = bsy; e.srclr = srclr;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int code, input int idx, input int srclr);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
            check("load_sym_code", code, e.code);
            check("load_cur_idx", idx, e.idx);
        end
        if (e.kind == 2) begin
            check("busy_cycles", bcnt, e.bsy);
            check("done_sr_clear", srclr, e.srclr);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (shift && !load_n) check("shift_load_overlap", 1, 0);
            if (!load_n) pop_cmp(0, int'(sym_code), int'(cur_idx), 0);
            if (shift) pop_cmp(1, 0, 0, 0);
            if (done) begin
                pop_cmp(2, 0, 0, int'(sr_clear));
                bcnt = 0;
            end
        end
    end

    task automatic push_msg(input int t0, input int n, input int limit);
        int tl, td, bsy;
        for (int i = 0; i < n; i++) begin
            tl = t0 + i * (LET + GAPC);
            if (tl <= limit) push_ev(0, tl, model_buf[i], i, 0, 0);
            for (int j = 1; j <= PW; j++)
                if (tl + j * TICK <= limit) push_ev(1, tl + j * TICK, 0, 0, 0, 0);
        end
        bsy = (n == 0) ? 0 : n * LET + (n - 1) * GAPC;
        td  = (n == 0) ? t0 : t0 + bsy;
        if (td <= limit) push_ev(2, td, 0, 0, bsy, 0);
    endtask

    task automatic start_msg(input int len, input int lim_off, output int t0);
        @(negedge clk); #1;
        msg_len = 4'(len);
        start   = 1'b1;
        t0      = cyc + 1;
        push_msg(t0, (len > ML) ? ML : len, (lim_off == NOLIM) ? NOLIM : t0 + lim_off);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic write_buf(input int addr, input int code);
        @(negedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'(addr); wr_code = 3'(code);
        if (!busy) model_buf[addr] = code;
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target, input string tag);
        int k = 0;
        while (cyc != target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, cyc, target);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_load_n"}, load_n, 1);
        check({pfx, "_shift"}, shift, 0);
        check({pfx, "_sr_clear"}, sr_clear, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_sym_code"}, sym_code, 0);
        check({pfx, "_cur_idx"}, cur_idx, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected < 50000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        int t0;
        for (int i = 0; i < ML; i++) model_buf[i] = 0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("rst_release_sr_clear", sr_clear, 0);

        // single letter T
        write_buf(0, 1);
        start_msg(1, NOLIM, t0);
        wait_drain(200);

        // two letters S, Z with gap
        write_buf(0, 0);
        write_buf(1, 7);
        start_msg(2, NOLIM, t0);
        wait_drain(300);

        // empty message
        start_msg(0, NOLIM, t0);
        wait_drain(20);

        // abort on the fifth shift of letter 0
        write_buf(2, 3);
        @(negedge clk); #1;
        msg_len = 4'd3;
        start   = 1'b1;
        t0      = cyc + 1;
        push_ev(0, t0, model_buf[0], 0, 0, 0);
        for (int j = 1; j <= 5; j++) push_ev(1, t0 + j * TICK, 0, 0, 0, 0);
        push_ev(2, t0 + 5 * TICK + 1, 0, 0, 5 * TICK + 1, 1);
        @(negedge clk); #1;
        start = 1'b0;
        wait_cyc(t0 + 5 * TICK, "abort_align");
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        wait_drain(50);
        check("abort_idle_busy", busy, 0);

        // start/write/abort-free disturbance while busy: in shift and in gap
        start_msg(2, NOLIM, t0);
        for (int r = 0; r < 2; r++) begin
            wait_cyc(t0 + ((r == 0) ? 10 : LET + 5), "busy_poke_align");
            wr_en = 1'b1; wr_addr = 3'd0; wr_code = 3'd5; start = 1'b1; msg_len = 4'd1;
            if (!busy) model_buf[0] = 5;
            @(negedge clk); #1;
            wr_en = 1'b0; start = 1'b0;
        end
        wait_drain(300);
        start_msg(2, NOLIM, t0);
        wait_drain(300);

        // full buffer with clamped length
        for (int i = 0; i < ML; i++) write_buf(i, (i * 3 + 1) % 8);
        start_msg(12, NOLIM, t0);
        wait_drain(1000);

        // reset mid-letter: nothing after the reset edge, buffer cleared
        start_msg(12, 100, t0);
        wait_cyc(t0 + 100, "reset_align");
        reset_n = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("midrst");
        check("midrst_pending_events", exp_q.size(), 0);
        for (int i = 0; i < ML; i++) model_buf[i] = 0;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("midrst_release_sr_clear", sr_clear, 0);
        start_msg(1, NOLIM, t0);
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
